ov5640_power_seq: RTL and testbench
===================================

# ov5640_power_seq

- Power-up and recovery sequencer for the OV5640 camera.
- Drives the sensor `PWDN` and `RESET` pins with the datasheet timing: 6 ms powered-down, 2 ms in reset, 21 ms settle.
- Releases `power_done`, which is the reset of the camera init/capture stage, and then watches that stage's `cfg_done`. If configuration stalls, it re-runs the power sequence a bounded number of times, then flags a fault.
- Sits directly upstream of the camera top and replaces the ad-hoc counters at the system top.

## Interface
Parameters:
- `CNT_6MS`, 300_000: power-down hold, in sys_clk cycles (50 MHz).
- `CNT_2MS`, 100_000: reset hold, in cycles.
- `CNT_21MS`, 1_050_000: post-reset settle, in cycles.
- `CFG_TIMEOUT`, 5_000_000: maximum cycles from `power_done` rising to `cfg_done` being seen.
- `DEBOUNCE`, 500_000: number of stable cycles required on `sw_1`.
- `MAX_RETRY`, 3: number of automatic re-sequences before fault.

Ports:
- `sys_clk`  in  1  system clock; all logic in this domain.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `sw_1`  in  1  camera power switch, asynchronous; high = camera on.
- `cfg_done`  in  1  register config complete, from the 25 MHz domain; level signal.
- `ov5640_pwdn`  out  1  sensor power-down, high = powered down.
- `ov5640_rst_n`  out  1  sensor reset, active-low.
- `power_done`  out  1  sequence complete; active-high release for the camera init stage.
- `cam_ready`  out  1  `power_done` is high and `cfg_done` has been seen.
- `seq_fault`  out  1  retries exhausted.
- `retry_cnt`  out  2  number of retries used since the last OFF.

## Operation
**Input conditioning**
- `sw_1` passes through a 2-FF synchronizer, then a debouncer.
- The debounced output `sw_db` takes the synchronized value after it has been stable for `DEBOUNCE` consecutive cycles.
- `cfg_done` passes through a 2-FF synchronizer to give `cfg_s`.

**State machine** (one shared down/up counter, cleared on every state entry):

| State | Outputs (pwdn / rst_n / power_done) | Exit |
|---|---|---|
| OFF | 1 / 0 / 0 | `sw_db`=1 → PWDN |
| PWDN | 1 / 0 / 0 | after `CNT_6MS` cycles → RST |
| RST | 0 / 0 / 0 | after `CNT_2MS` cycles → SETTLE |
| SETTLE | 0 / 1 / 0 | after `CNT_21MS` cycles → CFG |
| CFG | 0 / 1 / 1 | see below |
| READY | 0 / 1 / 1 | see below |
| FAULT | 1 / 0 / 0 | see below |

- In OFF, `retry_cnt` is 0 and `seq_fault` is 0.
- CFG:
  - `cfg_s`=1 → READY.
  - Counter reaches `CFG_TIMEOUT` and `retry_cnt` < `MAX_RETRY` → increment `retry_cnt`, go to PWDN.
  - Counter reaches `CFG_TIMEOUT` and retries are exhausted → FAULT.
- READY: `cam_ready`=1.
  - `cfg_s` falling does not cause an exit; `cfg_done` is sticky by contract.
- FAULT: `seq_fault`=1.
  - Held until `sw_db`=0.
- `sw_db`=0 in any state → OFF on the next edge. This has priority over every other transition, so a power-off mid-sequence aborts it.

## Timing
- Reset values:
  - `ov5640_pwdn`=1, `ov5640_rst_n`=0.
  - `power_done`=0, `cam_ready`=0, `seq_fault`=0, `retry_cnt`=0.
  - State = OFF, `sw_db`=0.
- All outputs are registered and decoded from the next state. Outputs change on the same edge as the state register; there is no combinational path from any input to any output.
- Each timed state lasts exactly N cycles: entry at edge k, exit at edge k+N (transition when count == N-1).
- Latency from `sw_1` rising to leaving OFF: 2 cycles (sync) + `DEBOUNCE` cycles + 1 cycle.
- `cfg_s` lags `cfg_done` by 2–3 sys_clk cycles.
- If `cfg_s` and the timeout coincide in the same cycle, `cfg_s` wins and the state goes to READY.
- Counter width: `$clog2` of the largest count parameter, currently 23 bits. A single counter is shared by all timed states.
- A retry re-enters PWDN, so `ov5640_pwdn`=1 and `ov5640_rst_n`=0 take effect on the same edge as `power_done` falls. This resets the downstream init stage.
- `sys_rst_n` asserted mid-sequence forces the reset values immediately, because the reset is asynchronous.

## Structure
- Package `ov5640_pwr_pkg`:
  - state enum (OFF, PWDN, RST, SETTLE, CFG, READY, FAULT);
  - default count constants;
  - counter width function.
- One sub-module, `sw_debounce`: synchronizer plus stability counter, parameter `DEBOUNCE`.
- The top-level counters and the `power_done` logic are removed, and this block is instantiated in their place.

## Test plan
Run with small parameters: `CNT_6MS`=6, `CNT_2MS`=2, `CNT_21MS`=21, `CFG_TIMEOUT`=50, `DEBOUNCE`=4, `MAX_RETRY`=2.
- **Nominal power-up:** reset released, `sw_1`=1 held, `cfg_done` high 10 cycles after `power_done`.
  - `pwdn` falls exactly 6 cycles after PWDN entry.
  - `rst_n` rises 2 cycles later.
  - `power_done` rises 21 cycles after that.
  - `cam_ready` rises 3 cycles after `cfg_done`.
- **Switch bounce:** `sw_1` pulses of 1–3 cycles, then held high.
  - No state leaves OFF until 4 stable cycles have been seen.
  - Outputs stay at reset values during the bounce.
- **Timeout with retry then success:** `cfg_done` never set for the first power-up, set on the retry.
  - `power_done` falls 50 cycles after rising.
  - `retry_cnt`=1.
  - The full PWDN/RST/SETTLE sequence repeats, then READY.
- **Fault:** `cfg_done` tied 0.
  - After 2 retries, `seq_fault`=1 with `pwdn`=1 and `rst_n`=0.
  - `sw_1` low for 4 cycles → OFF, `retry_cnt`=0, `seq_fault`=0.
- **Abort mid-sequence:** `sw_1` falls during SETTLE.
  - After the debounce, state is OFF with `pwdn`=1, `rst_n`=0, `power_done`=0.
  - Raising `sw_1` again restarts from PWDN with a full 6-cycle hold.
- **Asynchronous reset:** `sys_rst_n` pulsed low during CFG, not aligned to a clock edge.
  - All outputs go to reset values immediately.
  - After release, the sequence restarts only after a debounced `sw_1`.

Source files
------------

// File: rtl/ov5640_pwr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_pwr_pkg
// Description : Shared types and constants for the OV5640 power sequencer.
//               Contents: the sequencer state enum, the default hold/timeout
//               counts (50 MHz sys_clk), and helpers that size counters.
// Revision    : 1.0 - initial release
// ============================================================================
package ov5640_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_PWDN   = 3'd1,
    ST_RST    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CFG    = 3'd4,
    ST_READY  = 3'd5,
    ST_FAULT  = 3'd6
  } pwr_state_t;

  // Datasheet timing at 50 MHz
  localparam int c_CNT_6MS_DEF     = 300_000;
  localparam int c_CNT_2MS_DEF     = 100_000;
  localparam int c_CNT_21MS_DEF    = 1_050_000;
  localparam int c_CFG_TIMEOUT_DEF = 5_000_000;
  localparam int c_DEBOUNCE_DEF    = 500_000;
  localparam int c_MAX_RETRY_DEF   = 3;

  // Largest of four counts; used to size the shared state counter
  function automatic int max_count(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Bits needed to hold values 0..n-1 (never less than one bit)
  function automatic int cnt_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Two-flop synchronizer followed by a stability counter. The
//               output follows the synchronized input once it has held a new
//               value for DEBOUNCE consecutive cycles.
// Ports       : sys_clk   - system clock
//               sys_rst_n - asynchronous active-low reset
//               sw_async  - raw asynchronous switch input
//               sw_db     - debounced, synchronized switch level
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce
  import ov5640_pwr_pkg::*;
#(
  parameter int DEBOUNCE = c_DEBOUNCE_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic sw_async,
  output logic sw_db
);

  localparam int                c_CNT_W = cnt_bits(DEBOUNCE);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DEBOUNCE - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_db;
  logic [c_CNT_W-1:0] r_cnt;

  // The counter only runs while the synchronized level differs from the
  // debounced one; any return to the old level restarts the run.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= sw_async;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == c_LAST) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sw_db = r_db;

endmodule
`default_nettype wire

// File: rtl/ov5640_power_seq.sv
`default_nettype none
// ============================================================================
// Module      : ov5640_power_seq
// Description : OV5640 power-up / recovery sequencer. Drives PWDN and RESET
//               with datasheet timing, releases power_done to the camera
//               init stage, watches cfg_done and re-sequences on a stall up
//               to MAX_RETRY times before flagging a fault.
// Ports       : sys_clk, sys_rst_n   - clock, async active-low reset
//               sw_1                 - async camera power switch (1 = on)
//               cfg_done             - config complete (25 MHz domain, level)
//               ov5640_pwdn          - sensor power-down (1 = down)
//               ov5640_rst_n         - sensor reset, active-low
//               power_done           - release for camera init stage
//               cam_ready            - configured and ready
//               seq_fault            - retries exhausted
//               retry_cnt            - retries used since last OFF
// Revision    : 1.0 - initial release
// ============================================================================
module ov5640_power_seq
  import ov5640_pwr_pkg::*;
#(
  parameter int CNT_6MS     = c_CNT_6MS_DEF,
  parameter int CNT_2MS     = c_CNT_2MS_DEF,
  parameter int CNT_21MS    = c_CNT_21MS_DEF,
  parameter int CFG_TIMEOUT = c_CFG_TIMEOUT_DEF,
  parameter int DEBOUNCE    = c_DEBOUNCE_DEF,
  parameter int MAX_RETRY   = c_MAX_RETRY_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       sw_1,
  input  logic       cfg_done,
  output logic       ov5640_pwdn,
  output logic       ov5640_rst_n,
  output logic       power_done,
  output logic       cam_ready,
  output logic       seq_fault,
  output logic [1:0] retry_cnt
);

  localparam int c_CNT_W = cnt_bits(max_count(CNT_6MS, CNT_2MS, CNT_21MS, CFG_TIMEOUT));

  // A timed state of N cycles exits when the counter reads N-1
  localparam logic [c_CNT_W-1:0] c_PWDN_LAST   = c_CNT_W'(CNT_6MS - 1);
  localparam logic [c_CNT_W-1:0] c_RST_LAST    = c_CNT_W'(CNT_2MS - 1);
  localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(CNT_21MS - 1);
  localparam logic [c_CNT_W-1:0] c_CFG_LAST    = c_CNT_W'(CFG_TIMEOUT - 1);
  localparam logic [1:0]         c_MAX_RETRY   = 2'(MAX_RETRY);

  logic               w_sw_db;
  logic               r_cfg_m;
  logic               r_cfg_s;
  pwr_state_t         r_state;
  pwr_state_t         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_retry;
  logic [1:0]         w_retry_nxt;
  logic               r_pwdn;
  logic               r_rst_n;
  logic               r_power_done;
  logic               r_cam_ready;
  logic               r_fault;

  sw_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_sw_debounce (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sw_async  (sw_1),
    .sw_db     (w_sw_db)
  );

  // cfg_done is a level from the 25 MHz domain; a plain 2-flop sync suffices
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cfg_m <= 1'b0;
      r_cfg_s <= 1'b0;
    end else begin
      r_cfg_m <= cfg_done;
      r_cfg_s <= r_cfg_m;
    end
  end

  // Next-state logic. Switch-off overrides everything so a power-off aborts
  // the sequence from any state. In CFG a seen cfg_s beats a coincident
  // timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    if (!w_sw_db) begin
      w_state_nxt = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:    w_state_nxt = ST_PWDN;
        ST_PWDN:   if (r_cnt == c_PWDN_LAST)   w_state_nxt = ST_RST;
        ST_RST:    if (r_cnt == c_RST_LAST)    w_state_nxt = ST_SETTLE;
        ST_SETTLE: if (r_cnt == c_SETTLE_LAST) w_state_nxt = ST_CFG;
        ST_CFG: begin
          if (r_cfg_s) begin
            w_state_nxt = ST_READY;
          end else if (r_cnt == c_CFG_LAST) begin
            if (r_retry < c_MAX_RETRY) begin
              w_retry_nxt = r_retry + 2'd1;
              w_state_nxt = ST_PWDN;
            end else begin
              w_state_nxt = ST_FAULT;
            end
          end
        end
        ST_READY:  w_state_nxt = ST_READY;
        ST_FAULT:  w_state_nxt = ST_FAULT;
        default:   w_state_nxt = ST_OFF;
      endcase
    end
    if (w_state_nxt == ST_OFF) begin
      w_retry_nxt = 2'd0;
    end
  end

  // State, shared counter and outputs all update on the same edge; outputs
  // are decoded from the next state so nothing lags the state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= ST_OFF;
      r_cnt        <= '0;
      r_retry      <= 2'd0;
      r_pwdn       <= 1'b1;
      r_rst_n      <= 1'b0;
      r_power_done <= 1'b0;
      r_cam_ready  <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      r_retry      <= w_retry_nxt;
      r_pwdn       <= (w_state_nxt inside {ST_OFF, ST_PWDN, ST_FAULT});
      r_rst_n      <= (w_state_nxt inside {ST_SETTLE, ST_CFG, ST_READY});
      r_power_done <= (w_state_nxt inside {ST_CFG, ST_READY});
      r_cam_ready  <= (w_state_nxt == ST_READY);
      r_fault      <= (w_state_nxt == ST_FAULT);
    end
  end

  assign ov5640_pwdn  = r_pwdn;
  assign ov5640_rst_n = r_rst_n;
  assign power_done   = r_power_done;
  assign cam_ready    = r_cam_ready;
  assign seq_fault    = r_fault;
  assign retry_cnt    = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_ov5640_power_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov5640_power_seq
// Description : Directed self-checking bench for ov5640_power_seq using small
//               timing parameters (6/2/21, timeout 50, debounce 4, 2 retries).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov5640_power_seq;

  localparam int S_PWDN  = 0;
  localparam int S_RSTN  = 1;
  localparam int S_PD    = 2;
  localparam int S_READY = 3;
  localparam int S_FAULT = 4;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       sw_1;
  logic       cfg_done;
  logic       ov5640_pwdn;
  logic       ov5640_rst_n;
  logic       power_done;
  logic       cam_ready;
  logic       seq_fault;
  logic [1:0] retry_cnt;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  ov5640_power_seq #(
    .CNT_6MS     (6),
    .CNT_2MS     (2),
    .CNT_21MS    (21),
    .CFG_TIMEOUT (50),
    .DEBOUNCE    (4),
    .MAX_RETRY   (2)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sw_1         (sw_1),
    .cfg_done     (cfg_done),
    .ov5640_pwdn  (ov5640_pwdn),
    .ov5640_rst_n (ov5640_rst_n),
    .power_done   (power_done),
    .cam_ready    (cam_ready),
    .seq_fault    (seq_fault),
    .retry_cnt    (retry_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic pick(input int sel);
    case (sel)
      S_PWDN:  return ov5640_pwdn;
      S_RSTN:  return ov5640_rst_n;
      S_PD:    return power_done;
      S_READY: return cam_ready;
      default: return seq_fault;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Returns the edge number at which the output first shows val, or -1
  task automatic wait_sig(input int sel, input logic val, input int budget, output int edge_no);
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge sys_clk);
      #1;
      if (pick(sel) === val) begin
        edge_no = cyc;
        break;
      end
    end
  endtask

  task automatic go_off();
    sw_1     = 1'b0;
    cfg_done = 1'b0;
    tick(12);
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    sw_1      = 1'b0;
    cfg_done  = 1'b0;
    tick(3);
    checks++; if (ov5640_pwdn !== 1'b1) begin errors++; $display("FAIL rst_pwdn: got %b, expected 1", ov5640_pwdn); end
    checks++; if (ov5640_rst_n !== 1'b0) begin errors++; $display("FAIL rst_rst_n: got %b, expected 0", ov5640_rst_n); end
    checks++; if (power_done !== 1'b0) begin errors++; $display("FAIL rst_power_done: got %b, expected 0", power_done); end
    checks++; if (cam_ready !== 1'b0) begin errors++; $display("FAIL rst_cam_ready: got %b, expected 0", cam_ready); end
    checks++; if (seq_fault !== 1'b0) begin errors++; $display("FAIL rst_seq_fault: got %b, expected 0", seq_fault); end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL rst_retry_cnt: got %0d, expected 0", retry_cnt); end
    sys_rst_n = 1'b1;
    tick(10);
    checks++; if (ov5640_pwdn !== 1'b1 || power_done !== 1'b0) begin errors++; $display("FAIL off_idle: got pwdn=%b pd=%b, expected pwdn=1 pd=0", ov5640_pwdn, power_done); end
  endtask

  task automatic test_nominal();
    int e0, t1, t2, t3, t4, tc;
    sw_1 = 1'b1;
    e0 = cyc;
    wait_sig(S_PWDN, 1'b0, 60, t1);
    checks++; if (t1 !== e0 + 13) begin errors++; $display("FAIL nom_pwdn_fall: got edge %0d, expected %0d", t1, e0 + 13); end
    wait_sig(S_RSTN, 1'b1, 20, t2);
    checks++; if (t2 !== t1 + 2) begin errors++; $display("FAIL nom_rstn_rise: got edge %0d, expected %0d", t2, t1 + 2); end
    wait_sig(S_PD, 1'b1, 40, t3);
    checks++; if (t3 !== t2 + 21) begin errors++; $display("FAIL nom_pd_rise: got edge %0d, expected %0d", t3, t2 + 21); end
    checks++; if (cam_ready !== 1'b0) begin errors++; $display("FAIL nom_ready_early: got %b, expected 0", cam_ready); end
    tick(10);
    cfg_done = 1'b1;
    tc = cyc;
    wait_sig(S_READY, 1'b1, 20, t4);
    checks++; if (t4 !== tc + 3) begin errors++; $display("FAIL nom_ready_rise: got edge %0d, expected %0d", t4, tc + 3); end
    checks++; if (retry_cnt !== 2'd0 || seq_fault !== 1'b0) begin errors++; $display("FAIL nom_ready_flags: got retry=%0d fault=%b, expected 0/0", retry_cnt, seq_fault); end
    // cfg_done dropping must not leave READY
    cfg_done = 1'b0;
    tick(8);
    checks++; if (cam_ready !== 1'b1 || power_done !== 1'b1) begin errors++; $display("FAIL nom_sticky: got ready=%b pd=%b, expected 1/1", cam_ready, power_done); end
    go_off();
    checks++; if (ov5640_pwdn !== 1'b1 || ov5640_rst_n !== 1'b0 || cam_ready !== 1'b0) begin errors++; $display("FAIL nom_off: got pwdn=%b rstn=%b ready=%b, expected 1/0/0", ov5640_pwdn, ov5640_rst_n, cam_ready); end
  endtask

  task automatic test_bounce();
    int lvl[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    int len[8] = '{1, 2, 3, 1, 2, 3, 1, 1};
    bit bad;
    int eh, t1;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sw_1 = lvl[i][0];
      for (int j = 0; j < len[i]; j++) begin
        tick(1);
        if (ov5640_pwdn !== 1'b1 || ov5640_rst_n !== 1'b0 || power_done !== 1'b0) bad = 1'b1;
      end
    end
    tick(4);
    if (ov5640_pwdn !== 1'b1 || ov5640_rst_n !== 1'b0 || power_done !== 1'b0) bad = 1'b1;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL bounce_outputs: got disturbed=%b, expected 0", bad); end
    sw_1 = 1'b1;
    eh = cyc;
    wait_sig(S_PWDN, 1'b0, 60, t1);
    checks++; if (t1 !== eh + 13) begin errors++; $display("FAIL bounce_pwdn_fall: got edge %0d, expected %0d", t1, eh + 13); end
    go_off();
  endtask

  task automatic test_retry();
    int e0, t3, t5, t6, t7, t8, t9;
    sw_1 = 1'b1;
    e0 = cyc;
    wait_sig(S_PD, 1'b1, 80, t3);
    checks++; if (t3 !== e0 + 36) begin errors++; $display("FAIL retry_pd_rise: got edge %0d, expected %0d", t3, e0 + 36); end
    wait_sig(S_PD, 1'b0, 80, t5);
    checks++; if (t5 !== t3 + 50) begin errors++; $display("FAIL retry_pd_fall: got edge %0d, expected %0d", t5, t3 + 50); end
    checks++; if (retry_cnt !== 2'd1 || ov5640_pwdn !== 1'b1 || ov5640_rst_n !== 1'b0) begin errors++; $display("FAIL retry_reenter: got retry=%0d pwdn=%b rstn=%b, expected 1/1/0", retry_cnt, ov5640_pwdn, ov5640_rst_n); end
    wait_sig(S_PWDN, 1'b0, 20, t6);
    checks++; if (t6 !== t5 + 6) begin errors++; $display("FAIL retry_pwdn_fall: got edge %0d, expected %0d", t6, t5 + 6); end
    wait_sig(S_RSTN, 1'b1, 20, t7);
    checks++; if (t7 !== t6 + 2) begin errors++; $display("FAIL retry_rstn_rise: got edge %0d, expected %0d", t7, t6 + 2); end
    wait_sig(S_PD, 1'b1, 40, t8);
    checks++; if (t8 !== t7 + 21) begin errors++; $display("FAIL retry_pd_rise2: got edge %0d, expected %0d", t8, t7 + 21); end
    cfg_done = 1'b1;
    wait_sig(S_READY, 1'b1, 20, t9);
    checks++; if (t9 !== t8 + 3) begin errors++; $display("FAIL retry_ready: got edge %0d, expected %0d", t9, t8 + 3); end
    checks++; if (retry_cnt !== 2'd1) begin errors++; $display("FAIL retry_cnt_hold: got %0d, expected 1", retry_cnt); end
    go_off();
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL retry_cnt_clear: got %0d, expected 0", retry_cnt); end
  endtask

  task automatic test_fault();
    int e0, tf, ef, to;
    cfg_done = 1'b0;
    sw_1 = 1'b1;
    e0 = cyc;
    wait_sig(S_FAULT, 1'b1, 320, tf);
    checks++; if (tf !== e0 + 244) begin errors++; $display("FAIL fault_edge: got edge %0d, expected %0d", tf, e0 + 244); end
    checks++; if (ov5640_pwdn !== 1'b1 || ov5640_rst_n !== 1'b0 || power_done !== 1'b0) begin errors++; $display("FAIL fault_pins: got pwdn=%b rstn=%b pd=%b, expected 1/0/0", ov5640_pwdn, ov5640_rst_n, power_done); end
    checks++; if (retry_cnt !== 2'd2) begin errors++; $display("FAIL fault_retry: got %0d, expected 2", retry_cnt); end
    tick(20);
    checks++; if (seq_fault !== 1'b1 || ov5640_pwdn !== 1'b1) begin errors++; $display("FAIL fault_hold: got fault=%b pwdn=%b, expected 1/1", seq_fault, ov5640_pwdn); end
    sw_1 = 1'b0;
    ef = cyc;
    wait_sig(S_FAULT, 1'b0, 20, to);
    checks++; if (to !== ef + 7) begin errors++; $display("FAIL fault_clear_edge: got edge %0d, expected %0d", to, ef + 7); end
    checks++; if (retry_cnt !== 2'd0 || ov5640_pwdn !== 1'b1) begin errors++; $display("FAIL fault_off: got retry=%0d pwdn=%b, expected 0/1", retry_cnt, ov5640_pwdn); end
    tick(4);
  endtask

  task automatic test_abort();
    int ts, ea, t1, eb, t2;
    sw_1 = 1'b1;
    wait_sig(S_RSTN, 1'b1, 60, ts);
    tick(5);
    sw_1 = 1'b0;
    ea = cyc;
    wait_sig(S_RSTN, 1'b0, 20, t1);
    checks++; if (t1 !== ea + 7) begin errors++; $display("FAIL abort_edge: got edge %0d, expected %0d", t1, ea + 7); end
    checks++; if (ov5640_pwdn !== 1'b1 || power_done !== 1'b0) begin errors++; $display("FAIL abort_pins: got pwdn=%b pd=%b, expected 1/0", ov5640_pwdn, power_done); end
    tick(3);
    sw_1 = 1'b1;
    eb = cyc;
    wait_sig(S_PWDN, 1'b0, 40, t2);
    checks++; if (t2 !== eb + 13) begin errors++; $display("FAIL abort_restart: got edge %0d, expected %0d", t2, eb + 13); end
    go_off();
  endtask

  task automatic test_async_reset();
    int tp, ca, t1;
    sw_1 = 1'b1;
    wait_sig(S_PD, 1'b1, 80, tp);
    tick(3);
    #3 sys_rst_n = 1'b0;
    ca = cyc;
    #1;
    checks++; if (ov5640_pwdn !== 1'b1 || ov5640_rst_n !== 1'b0 || power_done !== 1'b0) begin errors++; $display("FAIL arst_pins: got pwdn=%b rstn=%b pd=%b, expected 1/0/0", ov5640_pwdn, ov5640_rst_n, power_done); end
    checks++; if (cam_ready !== 1'b0 || seq_fault !== 1'b0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL arst_flags: got ready=%b fault=%b retry=%0d, expected 0/0/0", cam_ready, seq_fault, retry_cnt); end
    #3 sys_rst_n = 1'b1;
    wait_sig(S_PWDN, 1'b0, 40, t1);
    checks++; if (t1 !== ca + 13) begin errors++; $display("FAIL arst_restart: got edge %0d, expected %0d", t1, ca + 13); end
    go_off();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bounce();
    test_retry();
    test_fault();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
